alu_seq: RTL and testbench

Parametrised, handshaked successor to the processor's combinational ALU/shifter. Accepts one operation per transaction on a valid/ready input. Produces a registered result and a persistent S/Z/C/V flag register. Logic/arithmetic ops complete in 1 cycle; shifts use an iterative 1-bit-per-cycle shifter, so latency scales with shift amount. Sits between register-file read and write-back in the multicycle datapath.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU/shifter that sits between register-file read and
// write-back in the multicycle datapath. One operation per transaction.
// Logic and arithmetic ops finish in one cycle. Shifts step one bit per
// cycle, so their latency grows with the shift amount. The S/Z/C/V flag
// register persists across transactions.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; op, a, b, shamt are sampled on accept
//   out_valid/out_ready result handshake
//   result              registered result
//   wr_en               result is to be written to the destination register
//   flags               {S,Z,C,V}
//   err                 the current result came from an illegal opcode
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request; non-shift ops complete on the accept edge
// S_SHIFT | one 1-bit shift step per cycle, cnt_q counts down to 1
// S_DONE  | out_valid=1; result, wr_en, err, flags held until out_ready
module alu_seq #(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           wr_en,
  output logic [3:0]     flags,
  output logic           err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SLR = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;

  state_e         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [1:0]     shop_q, shop_d;
  logic [3:0]     flags_q, flags_d;
  logic           wr_en_q, wr_en_d;
  logic           err_q, err_d;

  logic [W:0]     sum, diff;
  logic           add_v, sub_v;
  logic [W-1:0]   step_data;
  logic           step_c;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // ADD overflow: like-signed operands producing a result of the other sign.
  assign add_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  // SUB overflow: unlike-signed operands and the result sign departs from a.
  assign sub_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

  // One shift step; shop_q is the low two opcode bits of the shift group.
  always_comb begin
    step_data = sh_q;
    step_c    = 1'b0;
    case (shop_q)
      2'b00: begin
        step_data = {sh_q[W-2:0], 1'b0};
        step_c    = sh_q[W-1];
      end
      2'b01: begin
        // Rotate never loses a bit, so carry stays clear.
        step_data = {sh_q[W-2:0], sh_q[W-1]};
        step_c    = 1'b0;
      end
      2'b10: begin
        step_data = {1'b0, sh_q[W-1:1]};
        step_c    = sh_q[0];
      end
      default: begin
        step_data = {sh_q[W-1], sh_q[W-1:1]};
        step_c    = sh_q[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
    flags_d  = flags_q;
    wr_en_d  = wr_en_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          wr_en_d = 1'b1;
          err_d   = 1'b0;
          case (op)
            OP_ADD: begin
              result_d = sum[W-1:0];
              flags_d  = {sum[W-1], (sum[W-1:0] == '0), sum[W], add_v};
            end
            OP_SUB, OP_CMP: begin
              result_d = diff[W-1:0];
              flags_d  = {diff[W-1], (diff[W-1:0] == '0), diff[W], sub_v};
              if (op == OP_CMP) wr_en_d = 1'b0;
            end
            OP_AND: begin
              result_d = a & b;
              flags_d  = {result_d[W-1], (result_d == '0), 2'b00};
            end
            OP_OR: begin
              result_d = a | b;
              flags_d  = {result_d[W-1], (result_d == '0), 2'b00};
            end
            OP_XOR: begin
              result_d = a ^ b;
              flags_d  = {result_d[W-1], (result_d == '0), 2'b00};
            end
            OP_MOV: begin
              result_d = b;
              flags_d  = {b[W-1], (b == '0), 2'b00};
            end
            OP_OUT: begin
              result_d = a;
            end
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
              if (shamt == '0) begin
                result_d = b;
                flags_d  = {b[W-1], (b == '0), 2'b00};
              end else begin
                state_d = S_SHIFT;
                sh_d    = b;
                cnt_d   = shamt;
                shop_d  = op[1:0];
              end
            end
            default: begin
              result_d = '0;
              wr_en_d  = 1'b0;
              err_d    = 1'b1;
            end
          endcase
        end
      end

      S_SHIFT: begin
        sh_d  = step_data;
        cnt_d = cnt_q - SHW'(1);
        // Terminal count: this is the last step, result and flags land now.
        if (cnt_q == SHW'(1)) begin
          state_d  = S_DONE;
          result_d = step_data;
          flags_d  = {step_data[W-1], (step_data == '0), step_c, 1'b0};
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      shop_q   <= 2'b00;
      flags_q  <= 4'b0000;
      wr_en_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      shop_q   <= shop_d;
      flags_q  <= flags_d;
      wr_en_q  <= wr_en_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign wr_en     = wr_en_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W   = 16;
  localparam int SHW = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [SHW-1:0] shamt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           wr_en;
  logic [3:0]     flags;
  logic           err;

  int n_run;
  int n_fail;
  logic [3:0] mflags;

  alu_seq #(.W(W), .SHW(SHW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .wr_en    (wr_en),
    .flags    (flags),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [15:0] r;
    logic [3:0]  f;
    logic        we;
    logic [4:0]  lat;
  } dvec_t;

  // Reference: shifts as whole-word operator arithmetic, flags from the rules.
  task automatic model(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] sh, input logic [3:0] fin,
                       output logic [15:0] r, output logic [3:0] fo,
                       output logic we, output logic er, output int lat);
    logic [16:0] s17;
    logic [31:0] t;
    logic c, v, upd;
    we = 1'b1; er = 1'b0; lat = 1; upd = 1'b1; c = 1'b0; v = 1'b0; r = 16'h0;
    case (o)
      4'h0: begin
        s17 = {1'b0, av} + {1'b0, bv};
        r = s17[15:0]; c = s17[16];
        v = (av[15] == bv[15]) && (r[15] != av[15]);
      end
      4'h1, 4'h5: begin
        s17 = {1'b0, av} - {1'b0, bv};
        r = s17[15:0]; c = s17[16];
        v = (av[15] != bv[15]) && (r[15] != av[15]);
        if (o == 4'h5) we = 1'b0;
      end
      4'h2: r = av & bv;
      4'h3: r = av | bv;
      4'h4: r = av ^ bv;
      4'h6: r = bv;
      4'h7: begin r = av; upd = 1'b0; end
      4'h8: begin
        t = {16'h0, bv} << sh;
        r = t[15:0]; c = (sh != 4'd0) ? t[16] : 1'b0; lat = 1 + int'(sh);
      end
      4'h9: begin
        t = {bv, bv} << sh;
        r = t[31:16]; lat = 1 + int'(sh);
      end
      4'hA: begin
        t = {bv, 16'h0} >> sh;
        r = t[31:16]; c = (sh != 4'd0) ? t[15] : 1'b0; lat = 1 + int'(sh);
      end
      4'hB: begin
        t = $signed({bv, 16'h0}) >>> sh;
        r = t[31:16]; c = (sh != 4'd0) ? t[15] : 1'b0; lat = 1 + int'(sh);
      end
      default: begin r = 16'h0; we = 1'b0; er = 1'b1; upd = 1'b0; end
    endcase
    fo = upd ? {r[15], (r == 16'h0), c, v} : fin;
  endtask

  // Drives one transaction with out_ready=1 and returns what the DUT showed.
  task automatic run_op(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [3:0] sh,
                        output logic [15:0] r, output logic [3:0] f,
                        output logic we, output logic er, output int lat, output bit to);
    int n;
    @(negedge clk);
    op = o; a = av; b = bv; shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    to = !out_valid || (n >= 50);
    r = result; f = flags; we = wr_en; er = err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; a = 16'h0; b = 16'h0; shamt = 4'h0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({out_valid, result, flags, wr_en, err, in_ready} !== {1'b0, 16'h0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b r=%h f=%b we=%b err=%b rdy=%b, expected 0 0000 0000 0 0 1",
               out_valid, result, flags, wr_en, err, in_ready);
    end
    rst_n = 1'b1;
    mflags = 4'b0000;
  endtask

  task automatic test_directed();
    dvec_t tbl [14];
    logic [15:0] gr; logic [3:0] gf; logic gwe, gerr; int glat; bit to;
    tbl[0]  = '{4'h0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1001, 1'b1, 5'd1};
    tbl[1]  = '{4'h1, 16'h0000, 16'h0001, 4'd0, 16'hFFFF, 4'b1010, 1'b1, 5'd1};
    tbl[2]  = '{4'h5, 16'h0005, 16'h0005, 4'd0, 16'h0000, 4'b0100, 1'b0, 5'd1};
    tbl[3]  = '{4'h8, 16'h8001, 16'h8001, 4'd1, 16'h0002, 4'b0010, 1'b1, 5'd2};
    tbl[4]  = '{4'hA, 16'h0006, 16'h0006, 4'd2, 16'h0001, 4'b0010, 1'b1, 5'd3};
    tbl[5]  = '{4'hB, 16'h8001, 16'h8001, 4'd1, 16'hC000, 4'b1010, 1'b1, 5'd2};
    tbl[6]  = '{4'h9, 16'h8001, 16'h8001, 4'd4, 16'h0018, 4'b0000, 1'b1, 5'd5};
    tbl[7]  = '{4'hB, 16'h1234, 16'h8421, 4'd0, 16'h8421, 4'b1000, 1'b1, 5'd1};
    tbl[8]  = '{4'h8, 16'h0000, 16'hFFFF, 4'd0, 16'hFFFF, 4'b1000, 1'b1, 5'd1};
    tbl[9]  = '{4'h2, 16'hF0F0, 16'h0F0F, 4'd0, 16'h0000, 4'b0100, 1'b1, 5'd1};
    tbl[10] = '{4'h6, 16'h0001, 16'h8000, 4'd0, 16'h8000, 4'b1000, 1'b1, 5'd1};
    tbl[11] = '{4'h0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 4'b0110, 1'b1, 5'd1};
    tbl[12] = '{4'h1, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 4'b0001, 1'b1, 5'd1};
    tbl[13] = '{4'hA, 16'h0000, 16'h8000, 4'd15, 16'h0001, 4'b0000, 1'b1, 5'd16};
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, gr, gf, gwe, gerr, glat, to);
      n_run++;
      if (to || {gr, gf, gwe, gerr} !== {tbl[i].r, tbl[i].f, tbl[i].we, 1'b0}) begin
        n_fail++;
        $display("FAIL directed[%0d] op=%h: got r=%h f=%b we=%b err=%b to=%0d, expected r=%h f=%b we=%b err=0",
                 i, tbl[i].op, gr, gf, gwe, gerr, to, tbl[i].r, tbl[i].f, tbl[i].we);
      end
      n_run++;
      if (glat !== int'(tbl[i].lat)) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, expected %0d", i, glat, tbl[i].lat);
      end
      mflags = tbl[i].f;
    end
  endtask

  task automatic test_illegal_out();
    logic [15:0] gr; logic [3:0] gf; logic gwe, gerr; int glat; bit to;
    run_op(4'h0, 16'h7FFF, 16'h0001, 4'd0, gr, gf, gwe, gerr, glat, to);
    run_op(4'hE, 16'h5555, 16'hAAAA, 4'd3, gr, gf, gwe, gerr, glat, to);
    n_run++;
    if (to || {gr, gf, gwe, gerr} !== {16'h0000, 4'b1001, 1'b0, 1'b1} || glat !== 1) begin
      n_fail++;
      $display("FAIL illegal_op: got r=%h f=%b we=%b err=%b lat=%0d, expected r=0000 f=1001 we=0 err=1 lat=1",
               gr, gf, gwe, gerr, glat);
    end
    run_op(4'h7, 16'h1234, 16'h0000, 4'd0, gr, gf, gwe, gerr, glat, to);
    n_run++;
    if (to || {gr, gf, gwe, gerr} !== {16'h1234, 4'b1001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL out_op: got r=%h f=%b we=%b err=%b, expected r=1234 f=1001 we=1 err=0",
               gr, gf, gwe, gerr);
    end
    mflags = 4'b1001;
  endtask

  task automatic test_backpressure();
    logic [15:0] xr; logic [3:0] xf; logic xwe, xerr; int xlat;
    int n;
    model(4'h0, 16'h1111, 16'h2222, 4'd0, mflags, xr, xf, xwe, xerr, xlat);
    @(negedge clk);
    op = 4'h0; a = 16'h1111; b = 16'h2222; shamt = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    // A different request is presented while the block is busy.
    op = 4'h4; a = 16'hF0F0; b = 16'h0FF0; shamt = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_run++;
      if ({out_valid, in_ready, result, flags, wr_en, err} !== {1'b1, 1'b0, xr, xf, xwe, 1'b0}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b rdy=%b r=%h f=%b we=%b err=%b, expected ov=1 rdy=0 r=%h f=%b we=%b err=0",
                 i, out_valid, in_ready, result, flags, wr_en, err, xr, xf, xwe);
      end
    end
    mflags = xf;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure_release: got ov=%b rdy=%b, expected ov=0 rdy=1", out_valid, in_ready);
    end
    model(4'h4, 16'hF0F0, 16'h0FF0, 4'd7, mflags, xr, xf, xwe, xerr, xlat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    n_run++;
    if (!out_valid || {result, flags, wr_en, err} !== {xr, xf, xwe, xerr}) begin
      n_fail++;
      $display("FAIL held_request: got ov=%b r=%h f=%b we=%b err=%b, expected ov=1 r=%h f=%b we=%b err=%b",
               out_valid, result, flags, wr_en, err, xr, xf, xwe, xerr);
    end
    mflags = xf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] gr; logic [3:0] gf; logic gwe, gerr; int glat; bit to;
    run_op(4'h0, 16'h7FFF, 16'h0001, 4'd0, gr, gf, gwe, gerr, glat, to);
    @(negedge clk);
    op = 4'hA; a = 16'h0000; b = 16'hFFFF; shamt = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({out_valid, result, flags, wr_en, err} !== {1'b0, 16'h0, 4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_shift: got ov=%b r=%h f=%b we=%b err=%b, expected all zero",
               out_valid, result, flags, wr_en, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mflags = 4'b0000;
    #1;
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, expected 1", in_ready);
    end
    run_op(4'h0, 16'h0002, 16'h0003, 4'd0, gr, gf, gwe, gerr, glat, to);
    n_run++;
    if (to || {gr, gf, gwe, gerr} !== {16'h0005, 4'b0000, 1'b1, 1'b0} || glat !== 1) begin
      n_fail++;
      $display("FAIL add_after_reset: got r=%h f=%b we=%b err=%b lat=%0d, expected r=0005 f=0000 we=1 err=0 lat=1",
               gr, gf, gwe, gerr, glat);
    end
  endtask

  task automatic test_random();
    logic [15:0] gr, xr; logic [3:0] gf, xf; logic gwe, gerr, xwe, xerr;
    int glat, xlat; bit to;
    logic [3:0] o, sh; logic [15:0] av, bv;
    for (int i = 0; i < 120; i++) begin
      o  = 4'($urandom_range(0, 15));
      av = 16'($urandom);
      bv = 16'($urandom);
      sh = 4'($urandom);
      if (i % 8 == 0) av = bv;
      model(o, av, bv, sh, mflags, xr, xf, xwe, xerr, xlat);
      run_op(o, av, bv, sh, gr, gf, gwe, gerr, glat, to);
      n_run++;
      if (to || {gr, gf, gwe, gerr} !== {xr, xf, xwe, xerr}) begin
        n_fail++;
        $display("FAIL random[%0d] op=%h a=%h b=%h sh=%0d: got r=%h f=%b we=%b err=%b to=%0d, expected r=%h f=%b we=%b err=%b",
                 i, o, av, bv, sh, gr, gf, gwe, gerr, to, xr, xf, xwe, xerr);
      end
      n_run++;
      if (glat !== xlat) begin
        n_fail++;
        $display("FAIL random_latency[%0d] op=%h sh=%0d: got %0d, expected %0d", i, o, sh, glat, xlat);
      end
      mflags = xf;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] gr; logic [3:0] gf; logic gwe, gerr; int glat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(4'(i), 16'($urandom), 16'($urandom), 4'd0, gr, gf, gwe, gerr, glat, to);
      n_run++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got rdy=%b ov=%b after handshake, expected rdy=1 ov=0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_illegal_out();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
